// File: rtl/fft_butterfly_pipe.sv
// Fully pipelined radix-2 complex butterfly with per-operation DIT/DIF and /2 scaling.
// Stages: operand prep -> complex multiply -> round, combine, scale/saturate.
module fft_butterfly_pipe #(
    parameter int DATA_WIDTH    = 24,
    parameter int TWIDDLE_WIDTH = 24,
    parameter int TAG_WIDTH     = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_valid,
    input  logic                       i_mode,
    input  logic                       i_scale,
    input  logic [2*DATA_WIDTH-1:0]    i_data_a,
    input  logic [2*DATA_WIDTH-1:0]    i_data_b,
    input  logic [2*TWIDDLE_WIDTH-1:0] i_twiddle,
    input  logic [TAG_WIDTH-1:0]       i_tag,
    input  logic                       i_clr_ovf,
    output logic                       o_valid,
    output logic [2*DATA_WIDTH-1:0]    o_data_a_out,
    output logic [2*DATA_WIDTH-1:0]    o_data_b_out,
    output logic [TAG_WIDTH-1:0]       o_tag,
    output logic                       o_sat,
    output logic                       o_ovf_sticky
);
    localparam int XW    = DATA_WIDTH + 1;
    localparam int RW    = DATA_WIDTH + 2;
    localparam int SUM_W = 2*DATA_WIDTH + TWIDDLE_WIDTH;

    localparam logic signed [SUM_W-1:0] RND_HALF =
        {{(SUM_W-TWIDDLE_WIDTH+1){1'b0}}, 1'b1, {(TWIDDLE_WIDTH-2){1'b0}}};
    localparam logic signed [RW-1:0] MAX_V = {3'b000, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] MIN_V = {3'b111, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {MODE_DIT = 1'b0, MODE_DIF = 1'b1} bfly_mode_e;

    // ---------------- stage 1: operand preparation ----------------
    logic signed [DATA_WIDTH-1:0]    a_re, a_im, b_re, b_im;
    logic signed [TWIDDLE_WIDTH-1:0] w_re, w_im;
    logic signed [XW-1:0]            c_re_d, c_im_d, x_re_d, x_im_d;

    assign a_re = i_data_a[2*DATA_WIDTH-1:DATA_WIDTH];
    assign a_im = i_data_a[DATA_WIDTH-1:0];
    assign b_re = i_data_b[2*DATA_WIDTH-1:DATA_WIDTH];
    assign b_im = i_data_b[DATA_WIDTH-1:0];
    assign w_re = i_twiddle[2*TWIDDLE_WIDTH-1:TWIDDLE_WIDTH];
    assign w_im = i_twiddle[TWIDDLE_WIDTH-1:0];

    // Both forms share one multiplier: X is B (DIT) or A-B (DIF); C is A (DIT) or A+B (DIF).
    always_comb begin
        if (bfly_mode_e'(i_mode) == MODE_DIF) begin
            c_re_d = XW'(a_re) + XW'(b_re);
            c_im_d = XW'(a_im) + XW'(b_im);
            x_re_d = XW'(a_re) - XW'(b_re);
            x_im_d = XW'(a_im) - XW'(b_im);
        end else begin
            c_re_d = XW'(a_re);
            c_im_d = XW'(a_im);
            x_re_d = XW'(b_re);
            x_im_d = XW'(b_im);
        end
    end

    logic                            v1, sc1;
    bfly_mode_e                      m1;
    logic [TAG_WIDTH-1:0]            tag1;
    logic signed [XW-1:0]            c1_re, c1_im, x1_re, x1_im;
    logic signed [TWIDDLE_WIDTH-1:0] w1_re, w1_im;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1    <= 1'b0;
            sc1   <= 1'b0;
            m1    <= MODE_DIT;
            tag1  <= '0;
            c1_re <= '0;
            c1_im <= '0;
            x1_re <= '0;
            x1_im <= '0;
            w1_re <= '0;
            w1_im <= '0;
        end else begin
            v1    <= i_valid;
            sc1   <= i_scale;
            m1    <= bfly_mode_e'(i_mode);
            tag1  <= i_tag;
            c1_re <= c_re_d;
            c1_im <= c_im_d;
            x1_re <= x_re_d;
            x1_im <= x_im_d;
            w1_re <= w_re;
            w1_im <= w_im;
        end
    end

    // ---------------- stage 2: full-width complex multiply ----------------
    logic signed [SUM_W-1:0] p_re_d, p_im_d;

    always_comb begin
        p_re_d = SUM_W'(x1_re) * SUM_W'(w1_re) - SUM_W'(x1_im) * SUM_W'(w1_im);
        p_im_d = SUM_W'(x1_re) * SUM_W'(w1_im) + SUM_W'(x1_im) * SUM_W'(w1_re);
    end

    logic                    v2, sc2;
    bfly_mode_e              m2;
    logic [TAG_WIDTH-1:0]    tag2;
    logic signed [XW-1:0]    c2_re, c2_im;
    logic signed [SUM_W-1:0] p2_re, p2_im;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v2    <= 1'b0;
            sc2   <= 1'b0;
            m2    <= MODE_DIT;
            tag2  <= '0;
            c2_re <= '0;
            c2_im <= '0;
            p2_re <= '0;
            p2_im <= '0;
        end else begin
            v2    <= v1;
            sc2   <= sc1;
            m2    <= m1;
            tag2  <= tag1;
            c2_re <= c1_re;
            c2_im <= c1_im;
            p2_re <= p_re_d;
            p2_im <= p_im_d;
        end
    end

    // ---------------- stage 3: round, combine, scale/saturate ----------------
    function automatic logic [DATA_WIDTH:0] out_step(input logic signed [RW-1:0] v,
                                                     input logic scale);
        logic signed [RW-1:0] t;
        t = scale ? (v >>> 1) : v;
        if (t > MAX_V)
            out_step = {1'b1, MAX_V[DATA_WIDTH-1:0]};
        else if (t < MIN_V)
            out_step = {1'b1, MIN_V[DATA_WIDTH-1:0]};
        else
            out_step = {1'b0, t[DATA_WIDTH-1:0]};
    endfunction

    logic signed [RW-1:0] r_re, r_im, ya_re, ya_im, yb_re, yb_im;
    logic [DATA_WIDTH:0]  q_are, q_aim, q_bre, q_bim;

    always_comb begin
        r_re = RW'((p2_re + RND_HALF) >>> (TWIDDLE_WIDTH-1));
        r_im = RW'((p2_im + RND_HALF) >>> (TWIDDLE_WIDTH-1));
        if (m2 == MODE_DIT) begin
            ya_re = RW'(c2_re) + r_re;
            ya_im = RW'(c2_im) + r_im;
            yb_re = RW'(c2_re) - r_re;
            yb_im = RW'(c2_im) - r_im;
        end else begin
            ya_re = RW'(c2_re);
            ya_im = RW'(c2_im);
            yb_re = r_re;
            yb_im = r_im;
        end
        q_are = out_step(ya_re, sc2);
        q_aim = out_step(ya_im, sc2);
        q_bre = out_step(yb_re, sc2);
        q_bim = out_step(yb_im, sc2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_valid      <= 1'b0;
            o_tag        <= '0;
            o_data_a_out <= '0;
            o_data_b_out <= '0;
            o_sat        <= 1'b0;
            o_ovf_sticky <= 1'b0;
        end else begin
            o_valid      <= v2;
            o_tag        <= tag2;
            o_data_a_out <= {q_are[DATA_WIDTH-1:0], q_aim[DATA_WIDTH-1:0]};
            o_data_b_out <= {q_bre[DATA_WIDTH-1:0], q_bim[DATA_WIDTH-1:0]};
            o_sat        <= v2 & (q_are[DATA_WIDTH] | q_aim[DATA_WIDTH] |
                                  q_bre[DATA_WIDTH] | q_bim[DATA_WIDTH]);
            o_ovf_sticky <= (o_ovf_sticky & ~i_clr_ovf) | (o_valid & o_sat);
        end
    end

endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// Self-checking bench for fft_butterfly_pipe: scoreboard queue filled at drive time,
// popped when o_valid appears; directed cases also compared against literal results.
module tb_fft_butterfly_pipe;
    localparam int     DW   = 24;
    localparam int     TW   = 24;
    localparam int     GW   = 10;
    localparam longint MAXP = 8388607;
    localparam longint MINN = -8388608;

    logic            clk = 1'b0, reset = 1'b0;
    logic            i_valid = 1'b0, i_mode = 1'b0, i_scale = 1'b0, i_clr_ovf = 1'b0;
    logic [2*DW-1:0] i_data_a = '0, i_data_b = '0;
    logic [2*TW-1:0] i_twiddle = '0;
    logic [GW-1:0]   i_tag = '0;
    logic            o_valid, o_sat, o_ovf_sticky;
    logic [2*DW-1:0] o_data_a_out, o_data_b_out;
    logic [GW-1:0]   o_tag;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2*DW-1:0] a;
        logic [2*DW-1:0] b;
        logic [GW-1:0]   tag;
        logic            sat;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    fft_butterfly_pipe #(.DATA_WIDTH(DW), .TWIDDLE_WIDTH(TW), .TAG_WIDTH(GW)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_mode(i_mode), .i_scale(i_scale),
        .i_data_a(i_data_a), .i_data_b(i_data_b), .i_twiddle(i_twiddle), .i_tag(i_tag),
        .i_clr_ovf(i_clr_ovf), .o_valid(o_valid), .o_data_a_out(o_data_a_out),
        .o_data_b_out(o_data_b_out), .o_tag(o_tag), .o_sat(o_sat), .o_ovf_sticky(o_ovf_sticky)
    );

    function automatic logic [2*DW-1:0] cx(input longint re, input longint im);
        return {re[DW-1:0], im[DW-1:0]};
    endfunction

    function automatic longint ostep(input longint v, input bit scale, output bit sat);
        longint t;
        t   = scale ? (v >>> 1) : v;
        sat = 1'b0;
        if (t > MAXP) begin t = MAXP; sat = 1'b1; end
        else if (t < MINN) begin t = MINN; sat = 1'b1; end
        return t;
    endfunction

    function automatic exp_t model(input bit mode, input bit scale, input logic [2*DW-1:0] a,
                                   input logic [2*DW-1:0] b, input logic [2*TW-1:0] w,
                                   input logic [GW-1:0] tag);
        longint ar, ai, br, bi, wr, wi, cr, ci, xr, xi, pr, pi, rr, ri;
        longint yar, yai, ybr, ybi, v0, v1, v2, v3;
        bit f0, f1, f2, f3;
        exp_t e;
        ar = longint'($signed(a[2*DW-1:DW])); ai = longint'($signed(a[DW-1:0]));
        br = longint'($signed(b[2*DW-1:DW])); bi = longint'($signed(b[DW-1:0]));
        wr = longint'($signed(w[2*TW-1:TW])); wi = longint'($signed(w[TW-1:0]));
        if (mode) begin
            cr = ar + br; ci = ai + bi; xr = ar - br; xi = ai - bi;
        end else begin
            cr = ar; ci = ai; xr = br; xi = bi;
        end
        pr = xr * wr - xi * wi;
        pi = xr * wi + xi * wr;
        rr = (pr + 4194304) >>> 23;
        ri = (pi + 4194304) >>> 23;
        if (mode) begin
            yar = cr; yai = ci; ybr = rr; ybi = ri;
        end else begin
            yar = cr + rr; yai = ci + ri; ybr = cr - rr; ybi = ci - ri;
        end
        v0 = ostep(yar, scale, f0);
        v1 = ostep(yai, scale, f1);
        v2 = ostep(ybr, scale, f2);
        v3 = ostep(ybi, scale, f3);
        e.a   = {v0[DW-1:0], v1[DW-1:0]};
        e.b   = {v2[DW-1:0], v3[DW-1:0]};
        e.tag = tag;
        e.sat = f0 | f1 | f2 | f3;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input bit mode, input bit scale, input logic [2*DW-1:0] a,
                            input logic [2*DW-1:0] b, input logic [2*TW-1:0] w,
                            input logic [GW-1:0] tag);
        i_valid = 1'b1; i_mode = mode; i_scale = scale;
        i_data_a = a; i_data_b = b; i_twiddle = w; i_tag = tag;
        exp_q.push_back(model(mode, scale, a, b, w, tag));
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        n_checks++;
        if ({o_valid, o_sat, o_ovf_sticky, o_tag, o_data_a_out, o_data_b_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h, required all zero",
                     {o_valid, o_sat, o_ovf_sticky, o_tag, o_data_a_out, o_data_b_out});
        end
        #2 reset = 1'b1;
        tick(); tick();
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release_valid: got %b, required 0", o_valid);
        end
    endtask

    task automatic test_dit_latency();
        exp_t e;
        int lat;
        drive_op(1'b0, 1'b1, cx(10, 20), cx(5, 8), cx(MAXP, 0), 10'h3A5);
        tick();
        i_valid = 1'b0;
        lat = 1;
        while (o_valid !== 1'b1 && lat < 8) begin tick(); lat++; end
        n_checks++;
        if (lat != 3) begin
            n_fail++; $display("FAIL dit_latency: got %0d cycles, required 3", lat);
        end
        n_checks++;
        if (o_valid !== 1'b1 || exp_q.size() == 0) begin
            n_fail++; $display("FAIL dit_scaled: got no o_valid, required one output");
        end else begin
            e = exp_q.pop_front();
            if ({o_data_a_out, o_data_b_out, o_tag, o_sat} !== {e.a, e.b, e.tag, e.sat} ||
                o_data_a_out !== cx(7, 14) || o_data_b_out !== cx(2, 6)) begin
                n_fail++;
                $display("FAIL dit_scaled: got a=%h b=%h tag=%h sat=%b, required a=%h b=%h tag=%h sat=0",
                         o_data_a_out, o_data_b_out, o_tag, o_sat, cx(7, 14), cx(2, 6), e.tag);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_directed();
        logic [2*DW-1:0] ta[7], tb[7], ra[7], rb[7];
        logic [2*TW-1:0] tw[7];
        bit              tm[7], ts[7], rs[7];
        exp_t            e;
        int              k;
        ta[0] = cx(100, 50);   tb[0] = cx(20, -30);  tw[0] = cx(0, MINN);             tm[0] = 0; ts[0] = 1;
        ra[0] = cx(35, 15);    rb[0] = cx(65, 35);   rs[0] = 0;
        ta[1] = cx(-100, -50); tb[1] = cx(80, 60);   tw[1] = cx(5932525, -5932525);   tm[1] = 0; ts[1] = 1;
        ra[1] = cx(-1, -32);   rb[1] = cx(-100, -18); rs[1] = 0;
        ta[2] = cx(10, 20);    tb[2] = cx(5, 8);     tw[2] = cx(0, MINN);             tm[2] = 1; ts[2] = 0;
        ra[2] = cx(15, 28);    rb[2] = cx(12, -5);   rs[2] = 0;
        ta[3] = cx(0, 0);      tb[3] = cx(MINN, 0);  tw[3] = cx(MINN, 0);             tm[3] = 0; ts[3] = 0;
        ra[3] = cx(MAXP, 0);   rb[3] = cx(MINN, 0);  rs[3] = 1;
        ta[4] = cx(-199, -1);  tb[4] = cx(0, 0);     tw[4] = cx(0, 0);                tm[4] = 0; ts[4] = 1;
        ra[4] = cx(-100, -1);  rb[4] = cx(-100, -1); rs[4] = 0;
        ta[5] = cx(MINN, 5);   tb[5] = cx(MINN, -3); tw[5] = cx(MAXP, 0);             tm[5] = 1; ts[5] = 0;
        ra[5] = cx(MINN, 2);   rb[5] = cx(0, 8);     rs[5] = 1;
        ta[6] = cx(100, 200);  tb[6] = cx(30, -40);  tw[6] = cx(MINN, 0);             tm[6] = 0; ts[6] = 0;
        ra[6] = cx(70, 240);   rb[6] = cx(130, 160); rs[6] = 0;
        k = 0;
        for (int c = 0; c < 20 && (c < 7 || exp_q.size() > 0); c++) begin
            if (c < 7) drive_op(tm[c], ts[c], ta[c], tb[c], tw[c], GW'(c));
            else i_valid = 1'b0;
            tick();
            if (o_valid === 1'b1 && exp_q.size() > 0 && k < 7) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({o_data_a_out, o_data_b_out, o_tag, o_sat} !== {e.a, e.b, e.tag, e.sat} ||
                    o_data_a_out !== ra[k] || o_data_b_out !== rb[k] || o_sat !== rs[k]) begin
                    n_fail++;
                    $display("FAIL directed_%0d: got a=%h b=%h tag=%h sat=%b, required a=%h b=%h tag=%h sat=%b",
                             k, o_data_a_out, o_data_b_out, o_tag, o_sat, ra[k], rb[k], e.tag, rs[k]);
                end
                k++;
            end
        end
        i_valid = 1'b0;
        n_checks++;
        if (k != 7) begin
            n_fail++; $display("FAIL directed_count: got %0d outputs, required 7", k);
        end
        exp_q.delete();
    endtask

    task automatic test_saturation();
        exp_t e;
        int   n;
        for (int r = 0; r < 2; r++) begin
            drive_op(1'b0, 1'b0, cx(MAXP, 0), cx(MAXP, 0), cx(MAXP, 0), GW'(r + 5));
            tick();
            i_valid = 1'b0;
            n = 0;
            while (o_valid !== 1'b1 && n < 8) begin tick(); n++; end
            n_checks++;
            if (o_valid !== 1'b1 || exp_q.size() == 0) begin
                n_fail++; $display("FAIL sat_output_%0d: got no o_valid, required one output", r);
            end else begin
                e = exp_q.pop_front();
                if ({o_data_a_out, o_data_b_out, o_tag, o_sat} !== {e.a, e.b, e.tag, e.sat} ||
                    o_data_a_out[2*DW-1:DW] !== 24'h7FFFFF || o_sat !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sat_output_%0d: got a=%h sat=%b, required a=%h sat=1",
                             r, o_data_a_out, o_sat, e.a);
                end
            end
            if (r == 0) begin
                tick();
                n_checks++;
                if (o_ovf_sticky !== 1'b1) begin
                    n_fail++; $display("FAIL sticky_set: got %b, required 1", o_ovf_sticky);
                end
                tick(); tick();
                n_checks++;
                if (o_ovf_sticky !== 1'b1 || o_sat !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sticky_hold: got sticky=%b sat=%b, required sticky=1 sat=0",
                             o_ovf_sticky, o_sat);
                end
            end else begin
                i_clr_ovf = 1'b1;
                tick();
                i_clr_ovf = 1'b0;
                n_checks++;
                if (o_ovf_sticky !== 1'b1) begin
                    n_fail++; $display("FAIL sticky_clr_vs_sat: got %b, required 1", o_ovf_sticky);
                end
                i_clr_ovf = 1'b1;
                tick();
                i_clr_ovf = 1'b0;
                n_checks++;
                if (o_ovf_sticky !== 1'b0) begin
                    n_fail++; $display("FAIL sticky_clear: got %b, required 0", o_ovf_sticky);
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   k, first, last;
        logic [2*DW-1:0] ra, rb;
        logic [2*TW-1:0] rw;
        k = 0; first = -1; last = -1;
        for (int c = 0; c < 40 && (c < 16 || exp_q.size() > 0); c++) begin
            if (c < 16) begin
                ra = (2*DW)'({$urandom(), $urandom()});
                rb = (2*DW)'({$urandom(), $urandom()});
                rw = (2*TW)'({$urandom(), $urandom()});
                drive_op(c[0], c[1], ra, rb, rw, GW'(c));
            end else begin
                i_valid = 1'b0;
            end
            tick();
            if (o_valid === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (first < 0) first = c;
                last = c;
                n_checks++;
                if ({o_data_a_out, o_data_b_out, o_tag, o_sat} !== {e.a, e.b, e.tag, e.sat} ||
                    o_tag !== GW'(k)) begin
                    n_fail++;
                    $display("FAIL stream_%0d: got a=%h b=%h tag=%0d sat=%b, required a=%h b=%h tag=%0d sat=%b",
                             k, o_data_a_out, o_data_b_out, o_tag, o_sat, e.a, e.b, k, e.sat);
                end
                k++;
            end
        end
        i_valid = 1'b0;
        n_checks++;
        if (k != 16 || last - first != 15) begin
            n_fail++;
            $display("FAIL stream_consecutive: got %0d outputs over %0d cycles, required 16 over 16",
                     k, last - first + 1);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   bad, n;
        drive_op(1'b0, 1'b0, cx(MAXP, 0), cx(MAXP, 0), cx(MAXP, 0), GW'(1));
        tick();
        i_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        exp_q.delete();
        n_checks++;
        if (o_ovf_sticky !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_sticky: got %b, required 1", o_ovf_sticky);
        end
        drive_op(1'b1, 1'b1, cx(1000, -2000), cx(300, 400), cx(MAXP, 0), GW'(2));
        tick();
        drive_op(1'b0, 1'b1, cx(-5000, 77), cx(12, -9), cx(0, MINN), GW'(3));
        tick();
        i_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({o_valid, o_sat, o_ovf_sticky, o_tag, o_data_a_out, o_data_b_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %h, required all zero",
                     {o_valid, o_sat, o_ovf_sticky, o_tag, o_data_a_out, o_data_b_out});
        end
        exp_q.delete();
        tick();
        #2 reset = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (o_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL reset_mid_no_valid: got %0d valid cycles, required 0", bad);
        end
        drive_op(1'b1, 1'b0, cx(10, 20), cx(5, 8), cx(0, MINN), GW'(9));
        tick();
        i_valid = 1'b0;
        n = 0;
        while (o_valid !== 1'b1 && n < 8) begin tick(); n++; end
        n_checks++;
        if (o_valid !== 1'b1 || exp_q.size() == 0) begin
            n_fail++; $display("FAIL post_reset_op: got no o_valid, required one output");
        end else begin
            e = exp_q.pop_front();
            if ({o_data_a_out, o_data_b_out, o_tag, o_sat} !== {e.a, e.b, e.tag, e.sat}) begin
                n_fail++;
                $display("FAIL post_reset_op: got a=%h b=%h tag=%h sat=%b, required a=%h b=%h tag=%h sat=%b",
                         o_data_a_out, o_data_b_out, o_tag, o_sat, e.a, e.b, e.tag, e.sat);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_dit_latency();
        test_directed();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
